// File: rtl/piezo_tune_sched.sv
// piezo_tune_sched
//   Picks one of three alert requesters for the single piezo tone generator
//   and plays the granted tune note by note. A repeat hold-off stops the
//   battery-low and steer-enable tunes from replaying back to back.
//
// Parameters
//   FAST_SIM   1: note durations shifted right by FAST_SHIFT, hold-off FAST_HOLD
//              0: full note durations, hold-off 150_000_000 clks
//   FAST_SHIFT right shift applied to the full durations when FAST_SIM=1
//   FAST_HOLD  hold-off length in clks when FAST_SIM=1
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous reset, active-high
//   too_fast     in   overspeed request, highest priority, level
//   batt_low     in   low-battery request, middle priority, level
//   en_steer     in   steer-enabled request, lowest priority, level
//   note_period  out  tone period in clks of the current note, 0 = silence
//   note_strobe  out  1-clk pulse on the first cycle of every new note
//   tune_id      out  0 none, 1 too_fast, 2 batt_low, 3 en_steer
//   busy         out  state is PLAY or HOLD
//   dbg_state    out  FSM state (0 IDLE, 1 PLAY, 2 HOLD)
module piezo_tune_sched #(
    parameter int FAST_SIM   = 1,
    parameter int FAST_SHIFT = 9,
    parameter int FAST_HOLD  = 5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        too_fast,
    input  logic        batt_low,
    input  logic        en_steer,
    output logic [14:0] note_period,
    output logic        note_strobe,
    output logic [1:0]  tune_id,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    localparam int          SHIFT     = (FAST_SIM != 0) ? FAST_SHIFT : 0;
    localparam logic [27:0] HOLD_LOAD = (FAST_SIM != 0) ? 28'(FAST_HOLD) : 28'd150_000_000;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [1:0] T_NONE  = 2'd0;
    localparam logic [1:0] T_FAST  = 2'd1;
    localparam logic [1:0] T_BATT  = 2'd2;
    localparam logic [1:0] T_STEER = 2'd3;

    function automatic logic [14:0] rom_period(input logic [2:0] idx);
        case (idx)
            3'd0:    rom_period = 15'd31888;
            3'd1:    rom_period = 15'd23890;
            3'd2:    rom_period = 15'd18961;
            3'd3:    rom_period = 15'd15944;
            3'd4:    rom_period = 15'd18961;
            3'd5:    rom_period = 15'd15944;
            default: rom_period = 15'd0;
        endcase
    endfunction

    function automatic logic [24:0] rom_dur(input logic [2:0] idx);
        logic [24:0] full;
        case (idx)
            3'd3:    full = 25'h0C0_0000;
            3'd4:    full = 25'h040_0000;
            3'd5:    full = 25'h100_0000;
            default: full = 25'h080_0000;
        endcase
        rom_dur = full >> SHIFT;
    endfunction

    logic [1:0]  r_state;
    logic [2:0]  r_idx;
    logic [1:0]  r_tune;
    logic [24:0] r_dur;
    logic [27:0] r_hold;
    logic [14:0] r_period;
    logic        r_strobe;

    logic [1:0]  w_state_nx;
    logic [2:0]  w_idx_nx;
    logic [1:0]  w_tune_nx;
    logic        w_start;
    logic        w_load_hold;
    logic        w_hold_zero;
    logic        w_last;
    logic [2:0]  w_idx_adv;
    logic [24:0] w_dur_nx;
    logic [27:0] w_hold_nx;
    logic [14:0] w_period_nx;
    logic        w_strobe_nx;

    assign w_hold_zero = (r_hold == 28'd0);

    // batt_low walks the ROM backwards; the other two walk forwards.
    always_comb begin
        w_last    = (r_idx == 3'd5);
        w_idx_adv = r_idx + 3'd1;
        case (r_tune)
            T_FAST: w_last = (r_idx == 3'd2);
            T_BATT: begin
                w_last    = (r_idx == 3'd0);
                w_idx_adv = r_idx - 3'd1;
            end
            default: ;
        endcase
    end

    // Next-state process.
    always_comb begin
        w_state_nx  = r_state;
        w_idx_nx    = r_idx;
        w_tune_nx   = r_tune;
        w_start     = 1'b0;
        w_load_hold = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (too_fast) begin
                    w_state_nx = S_PLAY; w_tune_nx = T_FAST;  w_idx_nx = 3'd0; w_start = 1'b1;
                end else if (batt_low && w_hold_zero) begin
                    w_state_nx = S_PLAY; w_tune_nx = T_BATT;  w_idx_nx = 3'd5; w_start = 1'b1;
                end else if (en_steer && w_hold_zero) begin
                    w_state_nx = S_PLAY; w_tune_nx = T_STEER; w_idx_nx = 3'd0; w_start = 1'b1;
                end
            end
            S_PLAY: begin
                if (too_fast && r_tune != T_FAST) begin
                    // Overspeed aborts a lower tune without arming the hold-off.
                    w_tune_nx = T_FAST; w_idx_nx = 3'd0; w_start = 1'b1;
                end else if (r_dur == 25'd0) begin
                    if (!w_last) begin
                        w_idx_nx = w_idx_adv; w_start = 1'b1;
                    end else if (r_tune == T_FAST && too_fast) begin
                        w_idx_nx = 3'd0; w_start = 1'b1;
                    end else if (r_tune == T_FAST) begin
                        w_state_nx = S_IDLE; w_tune_nx = T_NONE;
                    end else begin
                        w_state_nx = S_HOLD; w_tune_nx = T_NONE; w_load_hold = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (too_fast) begin
                    w_state_nx = S_PLAY; w_tune_nx = T_FAST; w_idx_nx = 3'd0; w_start = 1'b1;
                end else if (r_hold <= 28'd1) begin
                    // Leave on the same edge the hold-off counter reaches 0.
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE; w_tune_nx = T_NONE;
            end
        endcase
    end

    // Output process: next values of the registered outputs and counters.
    always_comb begin
        w_strobe_nx = w_start;
        w_period_nx = 15'd0;
        w_dur_nx    = 25'd0;
        if (w_start) begin
            w_period_nx = rom_period(w_idx_nx);
            w_dur_nx    = rom_dur(w_idx_nx) - 25'd1;
        end else if (w_state_nx == S_PLAY) begin
            w_period_nx = r_period;
            w_dur_nx    = (r_dur != 25'd0) ? r_dur - 25'd1 : 25'd0;
        end
        if (w_load_hold)
            w_hold_nx = HOLD_LOAD;
        else if (!w_hold_zero)
            w_hold_nx = r_hold - 28'd1;
        else
            w_hold_nx = 28'd0;
    end

    // State register process.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_idx    <= 3'd0;
            r_tune   <= T_NONE;
            r_dur    <= 25'd0;
            r_hold   <= 28'd0;
            r_period <= 15'd0;
            r_strobe <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_idx    <= w_idx_nx;
            r_tune   <= w_tune_nx;
            r_dur    <= w_dur_nx;
            r_hold   <= w_hold_nx;
            r_period <= w_period_nx;
            r_strobe <= w_strobe_nx;
        end
    end

    assign note_period = r_period;
    assign note_strobe = r_strobe;
    assign tune_id     = r_tune;
    assign busy        = (r_state != S_IDLE);
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_piezo_tune_sched.sv
// Directed bench for piezo_tune_sched. The DUT runs with a larger duration
// shift (14) and a 400-clk hold-off so every scenario stays short. With that
// scaling the note lengths are G6/C7/E7 512, G7(idx3) 768, E7(idx4) 256,
// G7(idx5) 1024 clks. Cycle n means n rising edges after reset release;
// outputs are sampled 1 ns after each edge.
module tb_piezo_tune_sched;

    localparam int HOLD = 400;

    logic        clk;
    logic        rst;
    logic        too_fast;
    logic        batt_low;
    logic        en_steer;
    logic [14:0] note_period;
    logic        note_strobe;
    logic [1:0]  tune_id;
    logic        busy;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    piezo_tune_sched #(
        .FAST_SIM   (1),
        .FAST_SHIFT (14),
        .FAST_HOLD  (HOLD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .too_fast    (too_fast),
        .batt_low    (batt_low),
        .en_steer    (en_steer),
        .note_period (note_period),
        .note_strobe (note_strobe),
        .tune_id     (tune_id),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic goto_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // Assert reset asynchronously and check that everything goes quiet at once.
    task automatic hit_reset(input string tag);
        rst = 1'b1;
        #1;
        check_eq({tag, "_period"}, 32'(note_period), 0);
        check_eq({tag, "_strobe"}, 32'(note_strobe), 0);
        check_eq({tag, "_tune"},   32'(tune_id),     0);
        check_eq({tag, "_busy"},   32'(busy),        0);
        check_eq({tag, "_state"},  32'(dbg_state),   0);
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic clear_inputs();
        too_fast = 1'b0;
        batt_low = 1'b0;
        en_steer = 1'b0;
    endtask

    // Strobe must be low the cycle before, high at c with the given note.
    task automatic expect_note(input string tag, input int c, input int period, input int tune);
        if (c > 1) begin
            goto_cycle(c - 1);
            check_eq({tag, "_pre_strobe"}, 32'(note_strobe), 0);
        end
        goto_cycle(c);
        check_eq({tag, "_strobe"}, 32'(note_strobe), 1);
        check_eq({tag, "_period"}, 32'(note_period), 32'(period));
        check_eq({tag, "_tune"},   32'(tune_id),     32'(tune));
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        #12;

        // 1: en_steer alone from reset, full tune, hold-off, replay.
        hit_reset("t1_rst");
        en_steer = 1'b1;
        release_rst();
        check_eq("t1_c0_period", 32'(note_period), 0);
        expect_note("t1_n0", 1, 31888, 3);
        goto_cycle(2);
        check_eq("t1_c2_strobe", 32'(note_strobe), 0);
        check_eq("t1_c2_period", 32'(note_period), 31888);
        check_eq("t1_c2_busy",   32'(busy),        1);
        expect_note("t1_n1", 513,  23890, 3);
        expect_note("t1_n2", 1025, 18961, 3);
        expect_note("t1_n3", 1537, 15944, 3);
        expect_note("t1_n4", 2305, 18961, 3);
        expect_note("t1_n5", 2561, 15944, 3);
        goto_cycle(3584);
        check_eq("t1_last_period", 32'(note_period), 15944);
        goto_cycle(3585);
        check_eq("t1_hold_period", 32'(note_period), 0);
        check_eq("t1_hold_state",  32'(dbg_state),   2);
        check_eq("t1_hold_busy",   32'(busy),        1);
        check_eq("t1_hold_tune",   32'(tune_id),     0);
        check_eq("t1_hold_strobe", 32'(note_strobe), 0);
        goto_cycle(3585 + HOLD - 1);
        check_eq("t1_hold_end_busy", 32'(busy), 1);
        goto_cycle(3585 + HOLD);
        check_eq("t1_idle_busy",   32'(busy),        0);
        check_eq("t1_idle_strobe", 32'(note_strobe), 0);
        expect_note("t1_replay", 3585 + HOLD + 1, 31888, 3);

        // 2: batt_low and en_steer together; batt_low wins and plays in reverse.
        hit_reset("t2_rst");
        clear_inputs();
        batt_low = 1'b1;
        en_steer = 1'b1;
        release_rst();
        expect_note("t2_n5", 1, 15944, 2);
        goto_cycle(2);
        batt_low = 1'b0;
        expect_note("t2_n4", 1025, 18961, 2);
        expect_note("t2_n3", 1281, 15944, 2);
        expect_note("t2_n2", 2049, 18961, 2);
        expect_note("t2_n1", 2561, 23890, 2);
        expect_note("t2_n0", 3073, 31888, 2);
        goto_cycle(3585);
        check_eq("t2_hold_state", 32'(dbg_state), 2);
        goto_cycle(3585 + 200);
        check_eq("t2_wait_tune",   32'(tune_id),     0);
        check_eq("t2_wait_strobe", 32'(note_strobe), 0);
        expect_note("t2_steer", 3585 + HOLD + 1, 31888, 3);

        // 3: too_fast loops G6/C7/E7, then finishes its pass after release.
        hit_reset("t3_rst");
        clear_inputs();
        too_fast = 1'b1;
        release_rst();
        expect_note("t3_g6a", 1,    31888, 1);
        expect_note("t3_c7a", 513,  23890, 1);
        expect_note("t3_e7a", 1025, 18961, 1);
        expect_note("t3_wrap", 1537, 31888, 1);
        goto_cycle(1700);
        too_fast = 1'b0;
        expect_note("t3_c7b", 2049, 23890, 1);
        expect_note("t3_e7b", 2561, 18961, 1);
        goto_cycle(3072);
        check_eq("t3_end_busy", 32'(busy), 1);
        goto_cycle(3073);
        check_eq("t3_idle_busy",   32'(busy),        0);
        check_eq("t3_idle_period", 32'(note_period), 0);
        check_eq("t3_idle_strobe", 32'(note_strobe), 0);
        en_steer = 1'b1;
        expect_note("t3_no_holdoff", 3074, 31888, 3);

        // 4: too_fast preempts en_steer in note idx3; en_steer never resumes.
        hit_reset("t4_rst");
        clear_inputs();
        en_steer = 1'b1;
        release_rst();
        expect_note("t4_n3", 1537, 15944, 3);
        goto_cycle(1600);
        too_fast = 1'b1;
        expect_note("t4_preempt", 1601, 31888, 1);
        too_fast = 1'b0;
        en_steer = 1'b0;
        expect_note("t4_c7", 2113, 23890, 1);
        goto_cycle(3137);
        check_eq("t4_idle_busy", 32'(busy),    0);
        check_eq("t4_idle_tune", 32'(tune_id), 0);
        en_steer = 1'b1;
        expect_note("t4_fresh_steer", 3138, 31888, 3);

        // 5: too_fast 100 clks into HOLD grants immediately.
        hit_reset("t5_rst");
        clear_inputs();
        en_steer = 1'b1;
        release_rst();
        goto_cycle(2);
        en_steer = 1'b0;
        goto_cycle(3585);
        check_eq("t5_hold_state", 32'(dbg_state), 2);
        goto_cycle(3685);
        check_eq("t5_hold_strobe", 32'(note_strobe), 0);
        check_eq("t5_hold_period", 32'(note_period), 0);
        too_fast = 1'b1;
        expect_note("t5_fast", 3686, 31888, 1);
        check_eq("t5_fast_state", 32'(dbg_state), 1);
        too_fast = 1'b0;

        // 6: reset mid batt_low note, then restart from the first note.
        hit_reset("t6_pre");
        clear_inputs();
        batt_low = 1'b1;
        release_rst();
        expect_note("t6_n5", 1, 15944, 2);
        goto_cycle(600);
        check_eq("t6_mid_period", 32'(note_period), 15944);
        hit_reset("t6_mid");
        release_rst();
        expect_note("t6_restart", 1, 15944, 2);
        goto_cycle(2);
        check_eq("t6_restart_busy", 32'(busy), 1);

        clear_inputs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
